// File: rtl/data_mem_mmio_if.sv
// Data-side bus between the single-cycle core and the data memory system,
// plus the byte stream that drains the TX FIFO toward an external consumer.
interface data_mem_mmio_if;
    // core store/load port
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    // LED register view
    logic [7:0]  led;
    // TX byte stream
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output mem_write, addr, wdata, tx_ready,
        input  rdata, led, tx_valid, tx_data
    );

    modport slave (
        input  mem_write, addr, wdata, tx_ready,
        output rdata, led, tx_valid, tx_data
    );
endinterface

// File: rtl/data_mem_mmio.sv
// Data memory system for the single-cycle core: word RAM below 0x8000_0000,
// MMIO block above it (LED, free-running cycle counter, TX byte FIFO, status).
// Loads are combinational so the core can complete a load in one cycle.
module data_mem_mmio #(
    parameter int unsigned RAM_AW  = 8,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_mmio_if.slave  bus
);

    localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] REG_LED  = 2'd0;
    localparam logic [1:0] REG_CNT  = 2'd1;
    localparam logic [1:0] REG_TXD  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    // storage
    logic [31:0]        ram_q  [RAM_DEPTH];
    logic [7:0]         fifo_q [FIFO_DEPTH];

    // architectural state
    logic [7:0]         led_q,    led_d;
    logic [31:0]        cnt_q,    cnt_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   count_q,  count_d;
    logic               ovf_q,    ovf_d;

    // address decode
    logic               is_mmio;
    logic [RAM_AW-1:0]  ram_idx;
    logic [1:0]         reg_sel;
    logic               wr_ram, wr_led, wr_cnt, wr_txd, wr_stat;

    // FIFO handshake
    logic               fifo_empty, fifo_full;
    logic               pop, push_ok, push_drop;

    // Address bits that never take part in the decode (byte offset, alias bits)
    logic               unused_addr_bits;

    assign is_mmio = bus.addr[31];
    assign ram_idx = bus.addr[RAM_AW+1:2];
    assign reg_sel = bus.addr[3:2];

    assign unused_addr_bits = ^{bus.addr[30:RAM_AW+2], bus.addr[1:0]};

    assign wr_ram  = bus.mem_write && !is_mmio;
    assign wr_led  = bus.mem_write &&  is_mmio && (reg_sel == REG_LED);
    assign wr_cnt  = bus.mem_write &&  is_mmio && (reg_sel == REG_CNT);
    assign wr_txd  = bus.mem_write &&  is_mmio && (reg_sel == REG_TXD);
    assign wr_stat = bus.mem_write &&  is_mmio && (reg_sel == REG_STAT);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));

    // A pop needs a valid head, so a push into an empty FIFO never pairs with a pop.
    // When full, a same-cycle pop frees the slot the push lands in.
    assign pop       = !fifo_empty && bus.tx_ready;
    assign push_ok   = wr_txd && (!fifo_full || pop);
    assign push_drop = wr_txd && fifo_full && !pop;

    assign bus.led      = led_q;
    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_q[rd_ptr_q];

    // Next-state for registers, counter and FIFO bookkeeping
    always_comb begin
        led_d    = led_q;
        cnt_d    = cnt_q + 32'd1;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (wr_led) begin
            led_d = bus.wdata[7:0];
        end

        // A load takes the written value as-is; counting resumes next cycle.
        if (wr_cnt) begin
            cnt_d = bus.wdata;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: count_d = count_q;
        endcase

        if (wr_stat) begin
            ovf_d = 1'b0;
        end else if (push_drop) begin
            ovf_d = 1'b1;
        end
    end

    // State register with synchronous reset; reset wins over any store or pop
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // RAM store port; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && wr_ram) begin
            ram_q[ram_idx] <= bus.wdata;
        end
    end

    // FIFO entry write; stale entries are harmless because occupancy gates them
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            fifo_q[wr_ptr_q] <= bus.wdata[7:0];
        end
    end

    // Zero-latency load mux from current state
    always_comb begin
        bus.rdata = '0;
        if (!is_mmio) begin
            bus.rdata = ram_q[ram_idx];
        end else begin
            unique case (reg_sel)
                REG_LED:  bus.rdata = {24'd0, led_q};
                REG_CNT:  bus.rdata = cnt_q;
                REG_TXD:  bus.rdata = '0;
                REG_STAT: bus.rdata = {20'd0, 8'(count_q), 1'b0, ovf_q, fifo_empty, fifo_full};
                default:  bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Bench for data_mem_mmio: directed scenarios with literal expectations, then
// a randomized phase checked against a queue/array reference model.
module tb_data_mem_mmio;

    localparam int unsigned RAM_AW     = 8;
    localparam int unsigned FIFO_AW    = 3;
    localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;

    localparam logic [31:0] A_LED  = 32'h8000_0000;
    localparam logic [31:0] A_CNT  = 32'h8000_0004;
    localparam logic [31:0] A_TXD  = 32'h8000_0008;
    localparam logic [31:0] A_STAT = 32'h8000_000C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_mmio_if bus_if ();

    data_mem_mmio #(.RAM_AW(RAM_AW), .FIFO_AW(FIFO_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // reference model state
    logic [31:0] ram_m [int unsigned];
    logic [7:0]  led_m = '0;
    logic [31:0] cnt_m = '0;
    bit          ovf_m = 1'b0;
    logic [7:0]  fq [$];
    // bytes expected to leave on tx_data, in order
    logic [7:0]  sb_tx [$];

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;
    rd_exp_t rd_q [$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned idx;
        int unsigned n;
        idx = (a >> 2) % RAM_DEPTH;
        n   = fq.size();
        if (a < 32'h8000_0000) begin
            if (ram_m.exists(idx)) return ram_m[idx];
            return 'x;
        end
        case ((a >> 2) % 4)
            0: return {24'd0, led_m};
            1: return cnt_m;
            2: return 32'd0;
            default: return 32'(n * 16 + (ovf_m ? 4 : 0) + (n == 0 ? 2 : 0) + (n == FIFO_DEPTH ? 1 : 0));
        endcase
    endfunction

    // reference model advances on every rising edge
    always @(posedge clk) begin
        bit          do_push;
        int unsigned idx;
        if (rst) begin
            led_m = '0;
            cnt_m = '0;
            ovf_m = 1'b0;
            fq.delete();
            sb_tx.delete();
        end else begin
            do_push = 1'b0;
            cnt_m   = cnt_m + 1;
            if (fq.size() > 0 && bus_if.tx_ready) void'(fq.pop_front());
            if (bus_if.mem_write) begin
                if (bus_if.addr < 32'h8000_0000) begin
                    idx = (bus_if.addr >> 2) % RAM_DEPTH;
                    ram_m[idx] = bus_if.wdata;
                end else begin
                    case ((bus_if.addr >> 2) % 4)
                        0: led_m = bus_if.wdata[7:0];
                        1: cnt_m = bus_if.wdata;
                        2: do_push = 1'b1;
                        default: ovf_m = 1'b0;
                    endcase
                end
            end
            if (do_push) begin
                if (fq.size() < FIFO_DEPTH) begin
                    fq.push_back(bus_if.wdata[7:0]);
                    sb_tx.push_back(bus_if.wdata[7:0]);
                end else begin
                    ovf_m = 1'b1;
                end
            end
        end
    end

    // monitor: compares mid-cycle, away from the rising edge
    always @(negedge clk) begin
        rd_exp_t e;
        if (mon_en) begin
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                check32(e.name, bus_if.rdata, e.exp);
            end
            check32("led", {24'd0, bus_if.led}, {24'd0, led_m});
            check32("tx_valid", {31'd0, bus_if.tx_valid}, {31'd0, sb_tx.size() != 0});
            if (bus_if.tx_valid && bus_if.tx_ready) begin
                if (sb_tx.size() > 0) check32("tx_data", {24'd0, bus_if.tx_data}, {24'd0, sb_tx.pop_front()});
                else check32("tx_unexpected_pop", 32'd1, 32'd0);
            end
        end
    end

    task automatic step(input bit r, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input bit rdy, input bit chk, input logic [31:0] exp, input string name);
        rd_exp_t e;
        rst              = r;
        bus_if.mem_write = we;
        bus_if.addr      = a;
        bus_if.wdata     = wd;
        bus_if.tx_ready  = rdy;
        if (chk) begin
            e.name = name;
            e.exp  = exp;
            rd_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit rdy);
        step(1'b0, 1'b1, a, d, rdy, 1'b0, '0, "");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name, input bit rdy);
        step(1'b0, 1'b0, a, '0, rdy, 1'b1, exp, name);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 32'h0, '0, rdy, 1'b0, '0, "");
    endtask

    // random step whose expected load value comes from the model
    task automatic rstep(input bit r, input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        logic [31:0] exp;
        exp = model_read(a);
        step(r, we, a, wd, rdy, !$isunknown(exp), exp, "rand_rdata");
    endtask

    initial begin
        int          op;
        bit          rdy;
        logic [31:0] a;
        logic [31:0] d;

        bus_if.mem_write = 1'b0;
        bus_if.addr      = '0;
        bus_if.wdata     = '0;
        bus_if.tx_ready  = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, '0, "");
        step(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, '0, "");
        mon_en = 1'b1;

        // RAM store, byte-offset ignore, high-bit aliasing
        wr(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd", 1'b0);
        rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_rd_offset", 1'b0);
        rd(32'h0000_0010 + (32'd4 << RAM_AW), 32'hDEAD_BEEF, "ram_rd_alias", 1'b0);

        // LED register and MMIO aliasing
        wr(A_LED, 32'h1234_56A5, 1'b0);
        rd(A_LED, 32'h0000_00A5, "led_rd", 1'b0);
        rd(32'h8000_0010, 32'h0000_00A5, "led_alias_rd", 1'b0);
        rd(A_TXD, 32'h0, "txd_rd", 1'b0);
        rd(32'hFFFF_FFF8, 32'h0, "txd_alias_rd", 1'b0);

        // cycle counter: count after reset, load, wrap
        step(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, '0, "");
        repeat (10) idle(1'b0);
        rd(A_CNT, 32'd10, "cnt_after_10", 1'b0);
        wr(A_CNT, 32'hFFFF_FFFE, 1'b0);
        rd(A_CNT, 32'hFFFF_FFFE, "cnt_load", 1'b0);
        rd(A_CNT, 32'hFFFF_FFFF, "cnt_max", 1'b0);
        rd(A_CNT, 32'h0000_0000, "cnt_wrap", 1'b0);

        // fill, overflow, drain, clear overflow
        for (int i = 1; i <= 8; i++) wr(A_TXD, 32'(i), 1'b0);
        rd(A_STAT, 32'h81, "stat_full", 1'b0);
        wr(A_TXD, 32'h09, 1'b0);
        rd(A_STAT, 32'h85, "stat_ovf", 1'b0);
        repeat (8) idle(1'b1);
        rd(A_STAT, 32'h06, "stat_empty_ovf", 1'b1);
        wr(A_STAT, 32'hFFFF_FFFF, 1'b0);
        rd(A_STAT, 32'h02, "stat_cleared", 1'b0);

        // push while full with a pop; push into empty while ready
        for (int i = 1; i <= 8; i++) wr(A_TXD, 32'(i), 1'b0);
        wr(A_TXD, 32'h55, 1'b1);
        rd(A_STAT, 32'h81, "stat_full_pushpop", 1'b0);
        repeat (8) idle(1'b1);
        rd(A_STAT, 32'h02, "stat_no_ovf", 1'b0);
        wr(A_TXD, 32'h77, 1'b1);
        rd(A_STAT, 32'h10, "stat_one", 1'b0);
        idle(1'b1);

        // reset in the middle of a drain
        wr(A_TXD, 32'hA1, 1'b0);
        wr(A_TXD, 32'hA2, 1'b0);
        wr(A_TXD, 32'hA3, 1'b0);
        wr(A_LED, 32'hFF, 1'b0);
        idle(1'b1);
        step(1'b1, 1'b0, 32'h0, '0, 1'b1, 1'b0, '0, "");
        rd(A_CNT, 32'd0, "cnt_post_rst0", 1'b1);
        rd(A_CNT, 32'd1, "cnt_post_rst1", 1'b1);
        rd(A_STAT, 32'h02, "stat_post_rst", 1'b1);
        rd(A_LED, 32'h0, "led_post_rst", 1'b1);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_kept", 1'b1);

        // randomized phase
        for (int it = 0; it < 600; it++) begin
            op  = int'($urandom_range(0, 99));
            rdy = ($urandom_range(0, 2) == 0);
            d   = $urandom;
            if (op < 45) begin
                a = ($urandom & 32'h7FFF_F000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
                rstep(1'b0, op < 22, a, d, rdy);
            end else begin
                a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFF0) | ($urandom & 32'h3);
                if (op < 62)      rstep(1'b0, 1'b1, a | 32'h8, d, rdy);
                else if (op < 68) rstep(1'b0, 1'b1, a, d, rdy);
                else if (op < 72) rstep(1'b0, 1'b1, a | 32'h4, d, rdy);
                else if (op < 76) rstep(1'b0, 1'b1, a | 32'hC, d, rdy);
                else if (op < 98) rstep(1'b0, 1'b0, a | (32'($urandom_range(0, 3)) << 2), d, rdy);
                else              rstep(1'b1, 1'b0, a | 32'hC, d, rdy);
            end
        end

        repeat (12) idle(1'b1);
        idle(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
